bus_arbiter: RTL and testbench

//  Central arbiter for the serial system bus shared by two master ports.
//  - Grants the bus round-robin on approval requests.
//  - Receives the granted master's serial slave-select, then drives one-hot slave enables.
//  - Holds bus_busy until the owner signals trans_done.
//  - Drives master_sel so the top level can mux the shared address/data/handshake lines.

---
 rtl/bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a two-master serial bus: grant, serial slave-index capture, one-hot slave enable.
// Optional BUSY watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int SLAVE_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                approval_request,
    input  logic [1:0]                tx_slave_select,
    input  logic [1:0]                trans_done,
    output logic [1:0]                approval_grant,
    output logic                      arbitor_busy,
    output logic                      bus_busy,
    output logic                      master_sel,
    output logic [2**SLAVE_LEN-1:0]   slave_sel,
    output logic                      timeout
);

    // state   | meaning
    // IDLE    | bus free, waiting for any request
    // SYNC    | one turnaround cycle after grant, owner drives index MSB
    // ADDR    | receiving remaining index bits
    // BUSY    | slave transaction in progress, waiting for owner's trans_done
    // RELEASE | one cycle with grant dropped before returning to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ADDR,
        S_BUSY,
        S_RELEASE
    } state_t;

    localparam int NSLV = 2**SLAVE_LEN;
    localparam int CW   = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;

    state_t              r_state, w_state_nxt;
    logic                r_owner, w_owner_nxt;
    logic                r_last_owner, w_last_owner_nxt;
    logic [SLAVE_LEN-1:0] r_idx, w_idx_nxt;
    logic [CW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [1:0]          r_grant, w_grant_nxt;
    logic                r_arb_busy, w_arb_busy_nxt;
    logic                r_bus_busy, w_bus_busy_nxt;
    logic                r_master_sel, w_master_sel_nxt;
    logic [NSLV-1:0]     r_slave_sel, w_slave_sel_nxt;
    logic                r_timeout, w_timeout_nxt;

    logic                w_winner;
    logic                w_own_req;
    logic                w_own_done;
    logic                w_own_bit;
    logic [SLAVE_LEN-1:0] w_idx_shift;
    logic [NSLV-1:0]     w_one_hot;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]       r_to_cnt, w_to_cnt_nxt;
`else
    logic                w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // On a tie the master that did not own the bus last time wins.
    assign w_winner    = (&approval_request) ? ~r_last_owner : approval_request[1];
    assign w_own_req   = approval_request[r_owner];
    assign w_own_done  = trans_done[r_owner];
    assign w_own_bit   = tx_slave_select[r_owner];
    assign w_idx_shift = SLAVE_LEN'({r_idx, w_own_bit});
    assign w_one_hot   = NSLV'(1) << r_idx;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_idx_nxt        = r_idx;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_grant_nxt      = r_grant;
        w_arb_busy_nxt   = r_arb_busy;
        w_bus_busy_nxt   = r_bus_busy;
        w_master_sel_nxt = r_master_sel;
        w_slave_sel_nxt  = r_slave_sel;
        w_timeout_nxt    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        w_to_cnt_nxt     = r_to_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (|approval_request) begin
                    w_state_nxt      = S_SYNC;
                    w_owner_nxt      = w_winner;
                    w_master_sel_nxt = w_winner;
                    w_grant_nxt      = 2'b01 << w_winner;
                    w_arb_busy_nxt   = 1'b1;
                    w_idx_nxt        = '0;
                end
            end
            S_SYNC: begin
                if (!w_own_req) begin
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_state_nxt   = S_ADDR;
                    w_idx_nxt     = w_idx_shift;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_ADDR: begin
                if (!w_own_req) begin
                    w_state_nxt = S_RELEASE;
                end else if (r_bit_cnt == CW'(SLAVE_LEN - 1)) begin
                    w_state_nxt     = S_BUSY;
                    w_arb_busy_nxt  = 1'b0;
                    w_bus_busy_nxt  = 1'b1;
                    w_slave_sel_nxt = w_one_hot;
`ifdef BUS_ARB_TIMEOUT_EN
                    w_to_cnt_nxt    = '0;
`endif
                end else begin
                    w_idx_nxt     = w_idx_shift;
                    w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                end
            end
            S_BUSY: begin
                if (w_own_done) begin
                    w_state_nxt = S_RELEASE;
`ifdef BUS_ARB_TIMEOUT_EN
                end else if (r_to_cnt == TW'(TIMEOUT_CYCLES)) begin
                    w_state_nxt   = S_RELEASE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TW'(1);
`endif
                end
            end
            S_RELEASE: begin
                w_state_nxt      = S_IDLE;
                w_last_owner_nxt = r_owner;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Every path into RELEASE (done, abort, timeout) drops the bus the same way.
        if (w_state_nxt == S_RELEASE) begin
            w_grant_nxt     = 2'b00;
            w_arb_busy_nxt  = 1'b0;
            w_bus_busy_nxt  = 1'b0;
            w_slave_sel_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_idx        <= '0;
            r_bit_cnt    <= '0;
            r_grant      <= 2'b00;
            r_arb_busy   <= 1'b0;
            r_bus_busy   <= 1'b0;
            r_master_sel <= 1'b0;
            r_slave_sel  <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_idx        <= w_idx_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_grant      <= w_grant_nxt;
            r_arb_busy   <= w_arb_busy_nxt;
            r_bus_busy   <= w_bus_busy_nxt;
            r_master_sel <= w_master_sel_nxt;
            r_slave_sel  <= w_slave_sel_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`endif

    assign approval_grant = r_grant;
    assign arbitor_busy   = r_arb_busy;
    assign bus_busy       = r_bus_busy;
    assign master_sel     = r_master_sel;
    assign slave_sel      = r_slave_sel;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level timeline model.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] approval_request;
    logic [1:0] tx_slave_select;
    logic [1:0] trans_done;
    wire  [1:0] approval_grant;
    wire        arbitor_busy;
    wire        bus_busy;
    wire        master_sel;
    wire  [3:0] slave_sel;
    wire        timeout;

    int n_cmp = 0;
    int n_err = 0;
    int m_last;
    logic [9:0] want;
    wire  [9:0] obs = {approval_grant, arbitor_busy, bus_busy, master_sel, slave_sel, timeout};

    bus_arbiter #(.SLAVE_LEN(2), .TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .approval_request (approval_request),
        .tx_slave_select  (tx_slave_select),
        .trans_done       (trans_done),
        .approval_grant   (approval_grant),
        .arbitor_busy     (arbitor_busy),
        .bus_busy         (bus_busy),
        .master_sel       (master_sel),
        .slave_sel        (slave_sel),
        .timeout          (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Output vector order: grant[1:0], arbitor_busy, bus_busy, master_sel, slave_sel[3:0], timeout.
    function automatic logic [9:0] ev(input logic [1:0] g, input logic ab, input logic bb,
                                      input logic ms, input logic [3:0] ss, input logic to);
        return {g, ab, bb, ms, ss, to};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        approval_request = 2'b00;
        tx_slave_select = 2'b00;
        trans_done = 2'b00;
        tick;
        tick;
        #3;
        reset = 1'b0;
        m_last = 1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        approval_request = 2'b00;
        tx_slave_select = 2'b00;
        trans_done = 2'b00;
        tick;
        want = ev(2'b00, 0, 0, 0, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL reset_state: got %b want %b", obs, want); end
        #3;
        reset = 1'b0;
        approval_request = 2'b01;
        tick;
        tx_slave_select[0] = 1'b0;
        tick;
        tx_slave_select[0] = 1'b1;
        tick;
        tick;
        want = ev(2'b01, 0, 1, 0, 4'b0010, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL pre_reset_busy: got %b want %b", obs, want); end
        #3;
        reset = 1'b1;
        #1;
        want = ev(2'b00, 0, 0, 0, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL async_reset: got %b want %b", obs, want); end
        approval_request = 2'b10;
        tick;
        #2;
        reset = 1'b0;
        tick;
        want = ev(2'b10, 1, 0, 1, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL m1_after_reset: got %b want %b", obs, want); end
        do_reset;
    endtask

    task automatic test_single;
        do_reset;
        approval_request = 2'b01;
        tick;
        want = ev(2'b01, 1, 0, 0, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL single_grant: got %b want %b", obs, want); end
        tx_slave_select[0] = 1'b1;
        tick;
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL single_sync: got %b want %b", obs, want); end
        tx_slave_select[0] = 1'b0;
        tick;
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL single_addr: got %b want %b", obs, want); end
        tick;
        want = ev(2'b01, 0, 1, 0, 4'b0100, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL single_busy: got %b want %b", obs, want); end
        trans_done = 2'b01;
        tick;
        want = ev(2'b00, 0, 0, 0, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL single_release: got %b want %b", obs, want); end
        trans_done = 2'b00;
        approval_request = 2'b00;
        tick;
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL single_idle: got %b want %b", obs, want); end
    endtask

    task automatic test_round_robin;
        do_reset;
        approval_request = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int o;
            int idx;
            logic [1:0] g;
            o = k % 2;
            g = 2'(1 << o);
            idx = $urandom_range(0, 3);
            tick;
            want = ev(g, 1, 0, o[0], 4'b0000, 0);
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, obs, want); end
            tx_slave_select[o] = idx[1];
            tick;
            tx_slave_select[o] = idx[0];
            tick;
            tick;
            want = ev(g, 0, 1, o[0], 4'(1 << idx), 0);
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL rr_busy%0d: got %b want %b", k, obs, want); end
            tick;
            tick;
            tick;
            trans_done[o] = 1'b1;
            tick;
            want = ev(2'b00, 0, 0, o[0], 4'b0000, 0);
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL rr_release%0d: got %b want %b", k, obs, want); end
            trans_done = 2'b00;
            tick;
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL rr_idle%0d: got %b want %b", k, obs, want); end
        end
    endtask

    task automatic test_abort;
        do_reset;
        approval_request = 2'b10;
        tick;
        want = ev(2'b10, 1, 0, 1, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL abort_grant: got %b want %b", obs, want); end
        approval_request = 2'b11;
        tick;
        approval_request = 2'b01;
        tick;
        want = ev(2'b00, 0, 0, 1, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL abort_release: got %b want %b", obs, want); end
        tick;
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL abort_idle: got %b want %b", obs, want); end
        tick;
        want = ev(2'b01, 1, 0, 0, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL abort_m0_grant: got %b want %b", obs, want); end
        do_reset;
    endtask

    task automatic test_ignore;
        int idx;
        do_reset;
        idx = $urandom_range(0, 3);
        approval_request = 2'b01;
        tick;
        tx_slave_select[0] = idx[1];
        tick;
        tx_slave_select[0] = idx[0];
        tick;
        tick;
        for (int j = 0; j < 4; j++) begin
            trans_done = (j % 2 == 0) ? 2'b10 : 2'b00;
            approval_request = (j == 1) ? 2'b00 : 2'b01;
            tick;
            want = ev(2'b01, 0, 1, 0, 4'(1 << idx), 0);
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL ignore_busy%0d: got %b want %b", j, obs, want); end
        end
        trans_done = 2'b01;
        approval_request = 2'b00;
        tick;
        want = ev(2'b00, 0, 0, 0, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL ignore_release: got %b want %b", obs, want); end
        do_reset;
    endtask

    task automatic test_timeout;
        do_reset;
        approval_request = 2'b01;
        tick;
        tx_slave_select[0] = 1'b1;
        tick;
        tick;
        tick;
        want = ev(2'b01, 0, 1, 0, 4'b1000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL to_busy1: got %b want %b", obs, want); end
`ifdef BUS_ARB_TIMEOUT_EN
        for (int m = 1; m <= 8; m++) begin
            tick;
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL to_busy%0d: got %b want %b", m + 1, obs, want); end
        end
        tick;
        want = ev(2'b00, 0, 0, 0, 4'b0000, 1);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL to_release: got %b want %b", obs, want); end
        approval_request = 2'b00;
        tick;
        want = ev(2'b00, 0, 0, 0, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL to_idle: got %b want %b", obs, want); end
`else
        for (int m = 1; m <= 99; m++) begin
            tick;
            if (m % 33 == 0) begin
                n_cmp++;
                if (obs !== want) begin n_err++; $display("FAIL to_still_busy%0d: got %b want %b", m + 1, obs, want); end
            end
        end
        trans_done = 2'b01;
        tick;
        want = ev(2'b00, 0, 0, 0, 4'b0000, 0);
        n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL to_late_release: got %b want %b", obs, want); end
`endif
        do_reset;
    endtask

    task automatic test_random(input int n);
        do_reset;
        for (int t = 0; t < n; t++) begin
            int r;
            int o;
            int idx;
            int d;
            int ab_at;
            logic aborted;
            logic [1:0] g;
            r = $urandom_range(1, 3);
            o = (r == 3) ? 1 - m_last : ((r == 2) ? 1 : 0);
            g = 2'(1 << o);
            idx = $urandom_range(0, 3);
            d = $urandom_range(1, 5);
            ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
            aborted = 1'b0;
            approval_request = r[1:0];
            trans_done = 2'b00;
            tick;
            want = ev(g, 1, 0, o[0], 4'b0000, 0);
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL rnd_grant t%0d: got %b want %b", t, obs, want); end
            for (int c = 0; c <= 2; c++) begin
                tx_slave_select = 2'($urandom_range(0, 3));
                if (c < 2) tx_slave_select[o] = idx[1 - c];
                if (c == ab_at) begin
                    approval_request[o] = 1'b0;
                    aborted = 1'b1;
                end
                tick;
                if (aborted) begin
                    want = ev(2'b00, 0, 0, o[0], 4'b0000, 0);
                    n_cmp++;
                    if (obs !== want) begin n_err++; $display("FAIL rnd_abort t%0d: got %b want %b", t, obs, want); end
                    break;
                end
                want = (c < 2) ? ev(g, 1, 0, o[0], 4'b0000, 0) : ev(g, 0, 1, o[0], 4'(1 << idx), 0);
                n_cmp++;
                if (obs !== want) begin n_err++; $display("FAIL rnd_seq t%0d c%0d: got %b want %b", t, c, obs, want); end
            end
            if (!aborted) begin
                for (int j = 1; j <= d; j++) begin
                    trans_done = 2'($urandom_range(0, 3));
                    trans_done[o] = (j == d);
                    tick;
                    want = (j < d) ? ev(g, 0, 1, o[0], 4'(1 << idx), 0) : ev(2'b00, 0, 0, o[0], 4'b0000, 0);
                    n_cmp++;
                    if (obs !== want) begin n_err++; $display("FAIL rnd_busy t%0d j%0d: got %b want %b", t, j, obs, want); end
                end
            end
            trans_done = 2'b00;
            m_last = o;
            if ($urandom_range(0, 1) == 1) approval_request = 2'b00;
            tick;
            want = ev(2'b00, 0, 0, o[0], 4'b0000, 0);
            n_cmp++;
            if (obs !== want) begin n_err++; $display("FAIL rnd_idle t%0d: got %b want %b", t, obs, want); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_abort;
        test_ignore;
        test_timeout;
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
